// File: rtl/temporizador_pkg.sv
// temporizador_pkg: shared state encoding and reset constants for the countdown timer
package temporizador_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;
  localparam logic [31:0] count_reset = '1;
endpackage

// File: rtl/contador_regresivo_cargable.sv
// contador_regresivo_cargable: loadable down-counter that saturates at zero
import temporizador_pkg::*;
module contador_regresivo_cargable #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [width-1:0] load_data,
  output logic [width-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= count_reset[width-1:0];
    else if (load) count <= load_data;
    else if (enable && count != '0) count <= count - 1'b1;
endmodule

// File: rtl/controlador_temporizador_regresivo.sv
// controlador_temporizador_regresivo: sequencing FSM turning the down-counter into a one-shot/auto-reload timer
import temporizador_pkg::*;
module controlador_temporizador_regresivo #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             mode_reload,
  input  logic [width-1:0] load_value,
  output logic [width-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);
  state_t state_q, state_d;
  logic [width-1:0] reload_reg, load_data;
  logic load, enable, done_d;
  contador_regresivo_cargable #(.width(width)) u_contador (
    .clk(clk),
    .reset(reset),
    .load(load),
    .enable(enable),
    .load_data(load_data),
    .count(count)
  );
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    enable = 1'b0;
    done_d = 1'b0;
    load_data = load_value;
    if (stop) state_d = IDLE;
    else if (start) begin
      state_d = RUN;
      load = 1'b1;
    end else if (state_q == RUN) begin
      if (pause) state_d = PAUSE;
      else if (count != '0) enable = 1'b1;
      else begin
        // terminal count: pulse done, then reload or park in DONE
        done_d = 1'b1;
        load = mode_reload;
        load_data = reload_reg;
        state_d = mode_reload ? RUN : DONE;
      end
    end else if (state_q == PAUSE && !pause) state_d = RUN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      reload_reg <= count_reset[width-1:0];
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      done <= done_d;
      if (start && !stop) reload_reg <= load_value;
    end
  assign busy = (state_q == RUN) || (state_q == PAUSE);
  assign state = state_q;
endmodule
